// File: rtl/pipelined_subtractor_if.sv
// pipelined_subtractor_if: operand/result valid-ready bundle for pipelined_subtractor.
interface pipelined_subtractor_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             of;
  modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, of);
  modport slave  (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, of);
endinterface

// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor: diff = a - b - bin, carry chain split over STAGES registered slices.
// Define SUB_SATURATE_EN to clamp diff on signed overflow in the final stage.
module pipelined_subtractor #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst_n,
  pipelined_subtractor_if.slave s
);
  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  logic             v  [L];
  logic             c  [L];
  logic [WIDTH-1:0] d  [L];
  logic [WIDTH-1:0] pa [L];
  logic [WIDTH-1:0] pb [L];
  logic             adv;
  assign adv = ~s.out_valid | s.out_ready;
  assign s.in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic             iv;
    logic             ic;
    logic [WIDTH-1:0] ia;
    logic [WIDTH-1:0] ib;
    logic [WIDTH-1:0] id;
    logic [WIDTH-1:0] nd;
    logic [S:0]       sum;
    if (k == 0) begin : g_in
      assign iv = s.in_valid;
      assign ic = ~s.bin;
      assign ia = s.a;
      assign ib = s.b;
      assign id = '0;
    end else begin : g_mid
      assign iv = v[k-1];
      assign ic = c[k-1];
      assign ia = pa[k-1];
      assign ib = pb[k-1];
      assign id = d[k-1];
    end
    // a - b - bin computed as a + ~b + ~bin, one slice per stage
    assign sum = {1'b0, ia[k*S +: S]} + {1'b0, ~ib[k*S +: S]} + (S+1)'(ic);
    always_comb begin
      nd = id;
      nd[k*S +: S] = sum[S-1:0];
    end
    if (k < L) begin : g_reg
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v[k]  <= 1'b0;
          c[k]  <= 1'b0;
          d[k]  <= '0;
          pa[k] <= '0;
          pb[k] <= '0;
        end else if (adv) begin
          v[k]  <= iv;
          c[k]  <= sum[S];
          d[k]  <= nd;
          pa[k] <= ia;
          pb[k] <= ib;
        end
    end else begin : g_out
      logic             ov;
      logic [WIDTH-1:0] res;
      assign ov = (ia[WIDTH-1] ^ ib[WIDTH-1]) & (nd[WIDTH-1] ^ ia[WIDTH-1]);
`ifdef SUB_SATURATE_EN
      assign res = ov ? {ia[WIDTH-1], {(WIDTH-1){~ia[WIDTH-1]}}} : nd;
`else
      assign res = nd;
`endif
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          s.out_valid <= 1'b0;
          s.diff      <= '0;
          s.bout      <= 1'b0;
          s.of        <= 1'b0;
        end else if (adv) begin
          s.out_valid <= iv;
          s.diff      <= res;
          s.bout      <= ~sum[S];
          s.of        <= ov;
        end
    end
  end
endmodule

// File: tb/tb_pipelined_subtractor.sv
// tb_pipelined_subtractor: random and directed checks against a wide-arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [33:0] expq [$];
  logic        stl = 1'b0;
  logic [34:0] prev;
  bit          done = 1'b0;
  pipelined_subtractor_if #(.WIDTH(32)) m ();
  pipelined_subtractor #(.WIDTH(32), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .s(m));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] u;
    longint      sd;
    logic        o;
    logic [31:0] r;
    u  = {1'b0, a} - {1'b0, b} - 33'(bin);
    sd = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    o  = (sd > 64'sh7FFFFFFF) || (sd < -64'sh80000000);
    r  = u[31:0];
`ifdef SUB_SATURATE_EN
    if (o) r = (sd > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
    return {o, u[32], r};
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      stl = 1'b0;
    end else begin
      if (stl) chk("hold", {m.out_valid, m.of, m.bout, m.diff}, prev);
      if (m.out_valid && !m.out_ready) chk("inrdy_stall", m.in_ready, 1'b0);
      if (m.out_valid && m.out_ready) begin
        if (expq.size() == 0) chk("extra_result", 1'b1, 1'b0);
        else chk("result", {m.of, m.bout, m.diff}, expq.pop_front());
      end
      if (m.in_valid && m.in_ready) expq.push_back(model(m.a, m.b, m.bin));
      stl  = m.out_valid & ~m.out_ready;
      prev = {m.out_valid, m.of, m.bout, m.diff};
    end
  end
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic bin);
    int t = 0;
    m.a = a;
    m.b = b;
    m.bin = bin;
    m.in_valid = 1'b1;
    #1;
    while (!m.in_ready && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (t >= 50) chk("accept_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    m.in_valid = 1'b0;
  endtask
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input logic [31:0] raw, input logic [31:0] sat, input logic bo, input logic o);
    int n = 0;
    op(a, b, bin);
    while (!m.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd3);
`ifdef SUB_SATURATE_EN
    chk({tag, "_diff"}, m.diff, sat);
`else
    chk({tag, "_diff"}, m.diff, raw);
`endif
    chk({tag, "_bout"}, m.bout, bo);
    chk({tag, "_of"}, m.of, o);
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    m.in_valid = 1'b0;
    m.a = '0;
    m.b = '0;
    m.bin = 1'b0;
    m.out_ready = 1'b1;
    #12;
    chk("rst_state", {m.out_valid, m.of, m.bout, m.diff}, 35'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    directed("t1", 32'h5, 32'h3, 1'b0, 32'h2, 32'h2, 1'b0, 1'b0);
    directed("t2", 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1);
    directed("t3", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1);
    directed("t4", 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    fork
      for (int i = 1; i <= 6; i++) op(32'(i) * 32'h11111111, 32'(i), 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        m.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m.out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("t5_drain", 64'(expq.size()), 64'd0);
    for (int i = 0; i < 3; i++) op(32'(i) + 32'h100, 32'h1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ov", m.out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t6_stale", m.out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    directed("t6", 32'h10, 32'h1, 1'b0, 32'hF, 32'hF, 1'b0, 1'b0);
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] ra, rb;
          ra = (i % 17 == 0) ? 32'h80000000 : $urandom;
          rb = (i % 13 == 0) ? 32'h7FFFFFFF : $urandom;
          op(ra, rb, 1'($urandom));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        m.out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    m.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("final_drain", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
